esp32_prog_bridge: RTL and testbench

Parametrised FTDI-to-ESP32 programming bridge for the ULX3S top level. Passes UART traffic between the FTDI and the ESP32, decodes the FTDI DTR/RTS pair into ESP32 EN/GPIO0 with a timed strap-hold phase on sd_d[0], and serves a button-state shift register to the ESP32 over the OLED/SD SPI pins. Unlike the single-purpose passthrough, all inputs are synchronised, the hold phase is a proper FSM with retrigger, and button width, SPI frame length, hold time and synchroniser depth are parameters.

---
 rtl/esp32_bridge_pkg.sv | 24 ++
 rtl/sync_ff.sv | 24 ++
 rtl/esp32_prog_bridge.sv | 171 +++++++++++++++++
 tb/tb_esp32_prog_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/esp32_bridge_pkg.sv
// Shared types and decode constants for the ESP32 programming bridge.
package esp32_bridge_pkg;

  typedef enum logic {
    StIdle,
    StHold
  } state_t;

  localparam logic [1:0] P_RUN   = 2'b11;
  localparam logic [1:0] P_BOOT  = 2'b01;
  localparam logic [1:0] P_RESET = 2'b10;

  // FTDI {ndtr, nrts} to ESP32 {en, gpio0}; the two active pairs swap.
  function automatic logic [1:0] f_decode(input logic [1:0] i_p);
    logic [1:0] w_dec;
    case (i_p)
      P_RESET: w_dec = P_BOOT;
      P_BOOT:  w_dec = P_RESET;
      default: w_dec = P_RUN;
    endcase
    return w_dec;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with a configurable reset value.
module sync_ff #(
  parameter int unsigned C_SYNC_STAGES = 2,
  parameter bit          C_RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [C_SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {C_SYNC_STAGES{C_RESET_VAL}};
    end else begin
      r_sync <= {r_sync[C_SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[C_SYNC_STAGES-1];

endmodule

// File: rtl/esp32_prog_bridge.sv
// FTDI-to-ESP32 programming bridge: UART passthrough, DTR/RTS strap decode with
// timed hold, and optional SPI button readback (PASSTHRU_SPI_READBACK_EN).
module esp32_prog_bridge
  import esp32_bridge_pkg::*;
#(
  parameter int unsigned C_RELEASE_BITS = 17,
  parameter int unsigned C_BUTTONS      = 7,
  parameter int unsigned C_SPI_BITS     = 8,
  parameter int unsigned C_SYNC_STAGES  = 2
) (
  input  logic                 clk_25MHz,
  input  logic                 rst_n,
  input  logic                 ftdi_txd,
  output logic                 ftdi_rxd,
  input  logic                 wifi_txd,
  output logic                 wifi_rxd,
  input  logic                 ftdi_ndtr,
  input  logic                 ftdi_nrts,
  input  logic                 boot_n,
  output logic                 wifi_en,
  output logic                 wifi_gpio0,
  input  logic                 spi_csn,
  input  logic                 spi_clk,
  input  logic [C_BUTTONS-1:0] buttons,
  output logic                 sd_d0_o,
  output logic                 sd_d0_oe,
  output logic                 prog_active
);

  logic                      w_ndtr;
  logic                      w_nrts;
  logic [1:0]                w_p;
  logic                      w_trig;
  logic [1:0]                r_p_prev;
  logic [1:0]                r_dec;
  state_t                    r_state;
  state_t                    w_state_d;
  logic [C_RELEASE_BITS-1:0] r_cnt;
  logic [C_RELEASE_BITS-1:0] w_cnt_d;
  logic                      w_rb_active;
  logic                      w_rb_bit;

  assign ftdi_rxd = wifi_txd;
  assign wifi_rxd = ftdi_txd;

  sync_ff #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_ndtr (
    .i_clk   (clk_25MHz),
    .i_rst_n (rst_n),
    .i_d     (ftdi_ndtr),
    .o_q     (w_ndtr)
  );

  sync_ff #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_nrts (
    .i_clk   (clk_25MHz),
    .i_rst_n (rst_n),
    .i_d     (ftdi_nrts),
    .o_q     (w_nrts)
  );

  assign w_p    = {w_ndtr, w_nrts};
  // Only a clean run-to-reset transition starts a hold.
  assign w_trig = (w_p == P_RESET) && (r_p_prev == P_RUN);

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_dec    <= P_RUN;
      r_p_prev <= P_RUN;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_dec    <= f_decode(w_p);
      r_p_prev <= w_p;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_trig) begin
          w_state_d = StHold;
          w_cnt_d   = '0;
        end
      end
      StHold: begin
        if (w_trig) begin
          w_cnt_d = '0;
        end else if (&r_cnt) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

`ifdef PASSTHRU_SPI_READBACK_EN
  logic                  w_csn;
  logic                  w_sclk;
  logic                  r_sclk_prev;
  logic [C_SPI_BITS-1:0] r_shreg;
  logic [C_SPI_BITS-1:0] w_btn_ext;

  sync_ff #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_csn (
    .i_clk   (clk_25MHz),
    .i_rst_n (rst_n),
    .i_d     (spi_csn),
    .o_q     (w_csn)
  );

  sync_ff #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk   (clk_25MHz),
    .i_rst_n (rst_n),
    .i_d     (spi_clk),
    .o_q     (w_sclk)
  );

  always_comb begin
    w_btn_ext                = '0;
    w_btn_ext[C_BUTTONS-1:0] = buttons;
  end

  // Rotate rather than shift so long frames repeat the button snapshot.
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      if (w_csn) begin
        r_shreg <= w_btn_ext;
      end else if (w_sclk && !r_sclk_prev) begin
        r_shreg <= {r_shreg[C_SPI_BITS-2:0], r_shreg[C_SPI_BITS-1]};
      end
    end
  end

  assign w_rb_active = !w_csn;
  assign w_rb_bit    = r_shreg[C_SPI_BITS-1];
`else
  logic w_unused;
  assign w_unused    = ^{spi_csn, spi_clk, buttons};
  assign w_rb_active = 1'b0;
  assign w_rb_bit    = 1'b0;
`endif

  always_comb begin
    sd_d0_oe = 1'b0;
    sd_d0_o  = 1'b0;
    if (r_state == StHold) begin
      sd_d0_oe = 1'b1;
      sd_d0_o  = r_dec[0];
    end else if (w_rb_active) begin
      sd_d0_oe = 1'b1;
      sd_d0_o  = w_rb_bit;
    end
  end

  assign wifi_en     = r_dec[1];
  assign wifi_gpio0  = r_dec[0] & boot_n;
  assign prog_active = (r_state == StHold);

endmodule

// File: tb/tb_esp32_prog_bridge.sv
// Self-checking bench for esp32_prog_bridge; follows PASSTHRU_SPI_READBACK_EN.
module tb_esp32_prog_bridge;

  localparam int unsigned C_RELEASE_BITS = 4;
  localparam int unsigned C_BUTTONS      = 7;
  localparam int unsigned C_SPI_BITS     = 8;
  localparam int unsigned C_SYNC_STAGES  = 2;
  localparam int unsigned HOLD_LEN       = 1 << C_RELEASE_BITS;
`ifdef PASSTHRU_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                 clk_25MHz = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 ftdi_txd  = 1'b1;
  logic                 wifi_txd  = 1'b1;
  logic                 ftdi_ndtr = 1'b1;
  logic                 ftdi_nrts = 1'b1;
  logic                 boot_n    = 1'b1;
  logic                 spi_csn   = 1'b1;
  logic                 spi_clk   = 1'b0;
  logic [C_BUTTONS-1:0] buttons   = '0;
  logic                 ftdi_rxd;
  logic                 wifi_rxd;
  logic                 wifi_en;
  logic                 wifi_gpio0;
  logic                 sd_d0_o;
  logic                 sd_d0_oe;
  logic                 prog_active;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q[$];

  esp32_prog_bridge #(
    .C_RELEASE_BITS (C_RELEASE_BITS),
    .C_BUTTONS      (C_BUTTONS),
    .C_SPI_BITS     (C_SPI_BITS),
    .C_SYNC_STAGES  (C_SYNC_STAGES)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .ftdi_txd    (ftdi_txd),
    .ftdi_rxd    (ftdi_rxd),
    .wifi_txd    (wifi_txd),
    .wifi_rxd    (wifi_rxd),
    .ftdi_ndtr   (ftdi_ndtr),
    .ftdi_nrts   (ftdi_nrts),
    .boot_n      (boot_n),
    .wifi_en     (wifi_en),
    .wifi_gpio0  (wifi_gpio0),
    .spi_csn     (spi_csn),
    .spi_clk     (spi_clk),
    .buttons     (buttons),
    .sd_d0_o     (sd_d0_o),
    .sd_d0_oe    (sd_d0_oe),
    .prog_active (prog_active)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_25MHz);
    #1;
  endtask

  task automatic set_p(input logic [1:0] p);
    {ftdi_ndtr, ftdi_nrts} = p;
  endtask

  // Counts consecutive HOLD cycles from now, flagging any cycle sd_d0 is not driven high.
  task automatic measure_hold(output int len, output int bad);
    len = 0;
    bad = 0;
    while (prog_active === 1'b1 && len < 4 * HOLD_LEN) begin
      if (sd_d0_oe !== 1'b1 || sd_d0_o !== 1'b1) bad++;
      len++;
      tick(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int                  len;
    int                  bad;
    logic [C_SPI_BITS-1:0] m;

    // Reset
    tick(2);
    check("rst_en", wifi_en, 1);
    check("rst_gpio0", wifi_gpio0, 1);
    check("rst_oe", sd_d0_oe, 0);
    check("rst_d0", sd_d0_o, 0);
    check("rst_prog", prog_active, 0);
    rst_n = 1'b1;
    tick(4);
    check("idle_en", wifi_en, 1);
    check("idle_gpio0", wifi_gpio0, 1);
    check("idle_oe", sd_d0_oe, 0);
    check("idle_prog", prog_active, 0);

    // UART passthrough
    ftdi_txd = 1'b0;
    wifi_txd = 1'b1;
    #1;
    check("uart_wifi_rxd0", wifi_rxd, 0);
    check("uart_ftdi_rxd1", ftdi_rxd, 1);
    ftdi_txd = 1'b1;
    wifi_txd = 1'b0;
    #1;
    check("uart_wifi_rxd1", wifi_rxd, 1);
    check("uart_ftdi_rxd0", ftdi_rxd, 0);
    wifi_txd = 1'b1;

    // Plain hold: 11 -> 10
    set_p(2'b10);
    tick(2);
    check("lat_pre_en", wifi_en, 1);
    check("lat_pre_prog", prog_active, 0);
    tick(1);
    check("hold_en", wifi_en, 0);
    check("hold_gpio0", wifi_gpio0, 1);
    check("hold_prog", prog_active, 1);
    measure_hold(len, bad);
    check("hold_len", len, HOLD_LEN);
    check("hold_d0_bad", bad, 0);
    check("post_hold_oe", sd_d0_oe, 0);
    check("post_hold_en", wifi_en, 0);

    // Retrigger at hold cycle 10 (cnt = 9)
    set_p(2'b11);
    tick(4);
    set_p(2'b10);
    tick(3);
    check("rt_enter", prog_active, 1);
    tick(9);
    set_p(2'b11);
    tick(1);
    set_p(2'b10);
    tick(3);
    check("rt_still", prog_active, 1);
    measure_hold(len, bad);
    check("rt_len", len, HOLD_LEN);
    check("rt_d0_bad", bad, 0);

    // 00 -> 10 must not trigger
    set_p(2'b00);
    tick(4);
    check("p00_en", wifi_en, 1);
    check("p00_prog", prog_active, 0);
    set_p(2'b10);
    tick(3);
    check("p00_10_en", wifi_en, 0);
    check("p00_10_prog", prog_active, 0);
    tick(HOLD_LEN / 2);
    check("p00_10_prog_late", prog_active, 0);

    // 01 with boot_n low
    set_p(2'b01);
    boot_n = 1'b0;
    tick(3);
    check("p01_en", wifi_en, 1);
    check("p01_gpio0", wifi_gpio0, 0);
    set_p(2'b11);
    tick(3);
    check("run_bootn0_gpio0", wifi_gpio0, 0);
    boot_n = 1'b1;
    #1;
    check("run_bootn1_gpio0", wifi_gpio0, 1);

    // Reset mid-hold
    set_p(2'b10);
    tick(3);
    tick(4);
    check("mid_hold_prog", prog_active, 1);
    set_p(2'b11);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_prog", prog_active, 0);
    check("mid_rst_oe", sd_d0_oe, 0);
    rst_n = 1'b1;
    tick(4);
    check("after_rst_prog", prog_active, 0);

    // SPI readback
    buttons = 7'h55;
    tick(3);
    m = '0;
    m[C_BUTTONS-1:0] = buttons;
    spi_csn = 1'b0;
    tick(1);
    check("csn_lat_oe", sd_d0_oe, 0);
    tick(1);
    exp_q.push_back(RB ? 32'(m[C_SPI_BITS-1]) : 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("spi_oe", sd_d0_oe, 32'(RB));
      if (exp_q.size() == 0) check("spi_q_empty", 1, 0);
      else check("spi_bit", sd_d0_o, exp_q.pop_front());
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
      m = {m[C_SPI_BITS-2:0], m[C_SPI_BITS-1]};
      if (i < 9) exp_q.push_back(RB ? 32'(m[C_SPI_BITS-1]) : 32'd0);
      tick(4);
    end
    spi_csn = 1'b1;
    tick(3);
    check("csn_high_oe", sd_d0_oe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
